// File: rtl/adi_spi_master_pkg.sv
// State encoding and counter sizing shared by the SPI initiator engine and its SCLK generator.
package adi_spi_master_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int HALF_CNT_W = 8;

  function automatic int edge_cnt_w(input int dlen);
    return $clog2(2 * dlen) + 1;
  endfunction

endpackage

// File: rtl/adi_spi_master_sclk_gen.sv
// SCLK generator: while run is high, toggles SCLK every CLK_DIV cycles, flagging each edge in the cycle before it
// appears on the pin; when run is low the counters clear and SCLK rests at CPOL, with no backpressure.
module adi_spi_master_sclk_gen
  import adi_spi_master_pkg::*;
#(
  parameter int CPOL    = 0,
  parameter int CLK_DIV = 2,
  parameter int DLEN    = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic first_edge,
  output logic last_edge
);

  localparam int ECW = edge_cnt_w(DLEN);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic [HALF_CNT_W-1:0] HALF_LAST = HALF_CNT_W'(CLK_DIV - 1);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(2 * DLEN - 1);

  logic [HALF_CNT_W-1:0] half_cnt;
  logic [ECW-1:0]        edge_cnt;
  logic                  tick;

  assign tick       = run && (half_cnt == HALF_LAST);
  assign lead_edge  = tick && (sclk == IDLE_LVL);
  assign trail_edge = tick && (sclk != IDLE_LVL);
  assign first_edge = tick && (edge_cnt == '0);
  assign last_edge  = tick && (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || !run) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= IDLE_LVL;
    end else if (tick) begin
      half_cnt <= '0;
      edge_cnt <= edge_cnt + ECW'(1);
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + HALF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/adi_spi_master_engine.sv
// SPI initiator: one full-duplex MSB-first word per command; CS held CS_TO_SCLK+(2*DATA_DLENGTH+1)*CLK_DIV cycles.
// s_cmd_ready stays low while the single rx word is unconsumed; ADI_SPI_MASTER_LOOPBACK_EN makes rx sample MOSI.
module adi_spi_master_engine
  import adi_spi_master_pkg::*;
#(
  parameter int CPOL         = 0,
  parameter int CPHA         = 0,
  parameter int INV_CS       = 0,
  parameter int DATA_DLENGTH = 16,
  parameter int CLK_DIV      = 2,
  parameter int CS_TO_SCLK   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  input  logic [DATA_DLENGTH-1:0] s_cmd_data,
  output logic                    m_rx_valid,
  input  logic                    m_rx_ready,
  output logic [DATA_DLENGTH-1:0] m_rx_data,
  output logic                    busy,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    spi_cs
);

  localparam logic CS_ON = (INV_CS != 0);
  localparam logic [HALF_CNT_W-1:0] SETUP_LAST = HALF_CNT_W'(CS_TO_SCLK - 1);
  localparam logic [HALF_CNT_W-1:0] DIV_LAST   = HALF_CNT_W'(CLK_DIV - 1);

  state_t                  state;
  logic [HALF_CNT_W-1:0]   cnt;
  logic [DATA_DLENGTH-2:0] tx_sr;
  logic [DATA_DLENGTH-1:0] rx_sr;
  logic lead_edge, trail_edge, first_edge, last_edge;
  logic sample_edge, shift_edge, rx_bit, rx_free_next;

  adi_spi_master_sclk_gen #(
    .CPOL    (CPOL),
    .CLK_DIV (CLK_DIV),
    .DLEN    (DATA_DLENGTH)
  ) u_sclk_gen (
    .clk        (clk),
    .resetn     (resetn),
    .run        (state == SHIFT),
    .sclk       (spi_sclk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .first_edge (first_edge),
    .last_edge  (last_edge)
  );

  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  // The opening leading edge (CPHA=1) and the closing trailing edge (CPHA=0) move no data out.
  assign shift_edge  = (CPHA != 0) ? (lead_edge && !first_edge) : (trail_edge && !last_edge);

`ifdef ADI_SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_bit      = spi_mosi;
`else
  assign rx_bit      = spi_miso;
`endif

  // rx buffer occupancy one cycle ahead, so s_cmd_ready can be registered without a bubble.
  assign rx_free_next = !(m_rx_valid && !m_rx_ready);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      s_cmd_ready <= 1'b0;
      m_rx_valid  <= 1'b0;
      m_rx_data   <= '0;
      busy        <= 1'b0;
      spi_mosi    <= 1'b0;
      spi_cs      <= ~CS_ON;
    end else begin
      if (m_rx_valid && m_rx_ready) m_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_cmd_valid && s_cmd_ready) begin
            state       <= SETUP;
            cnt         <= SETUP_LAST;
            tx_sr       <= s_cmd_data[DATA_DLENGTH-2:0];
            rx_sr       <= '0;
            spi_mosi    <= s_cmd_data[DATA_DLENGTH-1];
            spi_cs      <= CS_ON;
            busy        <= 1'b1;
            s_cmd_ready <= 1'b0;
          end else begin
            s_cmd_ready <= rx_free_next;
          end
        end
        SETUP: begin
          if (cnt == '0) state <= SHIFT;
          else cnt <= cnt - HALF_CNT_W'(1);
        end
        SHIFT: begin
          if (sample_edge) rx_sr <= {rx_sr[DATA_DLENGTH-2:0], rx_bit};
          if (shift_edge) begin
            spi_mosi <= tx_sr[DATA_DLENGTH-2];
            tx_sr    <= tx_sr << 1;
          end
          if (last_edge) begin
            state <= HOLD;
            cnt   <= DIV_LAST;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state      <= GAP;
            cnt        <= DIV_LAST;
            spi_cs     <= ~CS_ON;
            spi_mosi   <= 1'b0;
            m_rx_data  <= rx_sr;
            m_rx_valid <= 1'b1;
          end else begin
            cnt <= cnt - HALF_CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state       <= IDLE;
            busy        <= 1'b0;
            s_cmd_ready <= rx_free_next;
          end else begin
            cnt <= cnt - HALF_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adi_spi_master_engine.sv
// Directed bench: three engine instances (mode 0 / mode 3 / 8-bit inverted CS) against a behavioural SPI responder.
`timescale 1ns/1ps
module tb_adi_spi_master_engine;

  localparam logic [2:0] P_CPOL = 3'b010;
  localparam logic [2:0] P_CPHA = 3'b010;
  localparam logic [2:0] P_INV  = 3'b100;
  localparam int BOUND = 2000;
`ifdef ADI_SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  cmd_valid, cmd_ready, rx_valid, rx_ready, busy, sclk, mosi, miso, cs;
  logic [15:0] d0_tx, d0_rx, d1_tx, d1_rx;
  logic [7:0]  d2_tx, d2_rx;

  logic [31:0] sl_tx  [3];
  logic [31:0] sl_out [3];
  logic [31:0] sl_in  [3];
  int          sl_rise [3];
  int          sl_cs_cyc [3];
  logic [2:0]  prev_sclk, prev_act;

  int n_pass = 0;
  int n_total = 0;

  adi_spi_master_engine #(.CPOL(0), .CPHA(0), .INV_CS(0), .DATA_DLENGTH(16), .CLK_DIV(2), .CS_TO_SCLK(2)) u0 (
    .clk(clk), .resetn(resetn), .s_cmd_valid(cmd_valid[0]), .s_cmd_ready(cmd_ready[0]), .s_cmd_data(d0_tx),
    .m_rx_valid(rx_valid[0]), .m_rx_ready(rx_ready[0]), .m_rx_data(d0_rx), .busy(busy[0]),
    .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]), .spi_cs(cs[0]));

  adi_spi_master_engine #(.CPOL(1), .CPHA(1), .INV_CS(0), .DATA_DLENGTH(16), .CLK_DIV(2), .CS_TO_SCLK(2)) u1 (
    .clk(clk), .resetn(resetn), .s_cmd_valid(cmd_valid[1]), .s_cmd_ready(cmd_ready[1]), .s_cmd_data(d1_tx),
    .m_rx_valid(rx_valid[1]), .m_rx_ready(rx_ready[1]), .m_rx_data(d1_rx), .busy(busy[1]),
    .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]), .spi_cs(cs[1]));

  adi_spi_master_engine #(.CPOL(0), .CPHA(0), .INV_CS(1), .DATA_DLENGTH(8), .CLK_DIV(1), .CS_TO_SCLK(1)) u2 (
    .clk(clk), .resetn(resetn), .s_cmd_valid(cmd_valid[2]), .s_cmd_ready(cmd_ready[2]), .s_cmd_data(d2_tx),
    .m_rx_valid(rx_valid[2]), .m_rx_ready(rx_ready[2]), .m_rx_data(d2_rx), .busy(busy[2]),
    .spi_sclk(sclk[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]), .spi_cs(cs[2]));

  function automatic int len_of(input int i);
    return (i == 2) ? 8 : 16;
  endfunction

  // Responder model: observes the bus mid-cycle and reacts to each SCLK edge seen while CS is active.
  initial begin
    logic act, lead;
    miso = '0;
    prev_sclk = '0;
    prev_act = '0;
    for (int i = 0; i < 3; i++) begin
      sl_tx[i] = '0; sl_out[i] = '0; sl_in[i] = '0; sl_rise[i] = 0; sl_cs_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        act = (cs[i] === P_INV[i]);
        if (act && !prev_act[i]) begin
          sl_out[i] = sl_tx[i] << (32 - len_of(i));
          sl_in[i] = '0;
          sl_rise[i] = 0;
          sl_cs_cyc[i] = 0;
          if (!P_CPHA[i]) begin
            miso[i] = sl_out[i][31];
            sl_out[i] = sl_out[i] << 1;
          end
        end
        if (act) sl_cs_cyc[i]++;
        if (act && (sclk[i] !== prev_sclk[i])) begin
          lead = (sclk[i] != P_CPOL[i]);
          if (sclk[i]) sl_rise[i]++;
          if (lead != P_CPHA[i]) begin
            sl_in[i] = {sl_in[i][30:0], mosi[i]};
          end else begin
            miso[i] = sl_out[i][31];
            sl_out[i] = sl_out[i] << 1;
          end
        end
        if (!act) miso[i] = 1'b0;
        prev_act[i] = act;
        prev_sclk[i] = sclk[i];
      end
    end
  end

  task automatic send_cmd(input int i, input logic [31:0] word);
    int n;
    @(negedge clk);
    case (i)
      0: d0_tx = word[15:0];
      1: d1_tx = word[15:0];
      default: d2_tx = word[7:0];
    endcase
    cmd_valid[i] = 1'b1;
    n = 0;
    while (cmd_ready[i] !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      n_total++;
      $display("FAIL cmd_accept_timeout: inst %0d s_cmd_ready=%b, required 1 within %0d cycles", i, cmd_ready[i], BOUND);
    end
    @(negedge clk);
    cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_rx(input int i, output logic [31:0] got);
    int n;
    n = 0;
    while (rx_valid[i] !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      n_total++;
      $display("FAIL rx_valid_timeout: inst %0d m_rx_valid=%b, required 1 within %0d cycles", i, rx_valid[i], BOUND);
    end
    case (i)
      0: got = {16'h0, d0_rx};
      1: got = {16'h0, d1_rx};
      default: got = {24'h0, d2_rx};
    endcase
    rx_ready[i] = 1'b1;
    @(negedge clk);
    rx_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cmd_valid = '0;
    rx_ready = '0;
    d0_tx = '0; d1_tx = '0; d2_tx = '0;
    repeat (3) @(negedge clk);
    n_total++; if (cmd_ready !== 3'b000) $display("FAIL reset_cmd_ready: got %b want 000", cmd_ready); else n_pass++;
    n_total++; if (rx_valid !== 3'b000) $display("FAIL reset_rx_valid: got %b want 000", rx_valid); else n_pass++;
    n_total++; if (busy !== 3'b000) $display("FAIL reset_busy: got %b want 000", busy); else n_pass++;
    n_total++; if (sclk !== 3'b010) $display("FAIL reset_sclk: got %b want 010", sclk); else n_pass++;
    n_total++; if (mosi !== 3'b000) $display("FAIL reset_mosi: got %b want 000", mosi); else n_pass++;
    n_total++; if (cs !== 3'b011) $display("FAIL reset_cs: got %b want 011", cs); else n_pass++;
    n_total++; if (d0_rx !== 16'h0000) $display("FAIL reset_rx_data: got %h want 0000", d0_rx); else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
    n_total++; if (cmd_ready !== 3'b111) $display("FAIL ready_after_reset: got %b want 111", cmd_ready); else n_pass++;
  endtask

  task automatic test_mode0();
    logic [31:0] got;
    logic [15:0] want;
    want = LB ? 16'hA5C3 : 16'hCAFE;
    sl_tx[0] = 32'hCAFE;
    send_cmd(0, 32'hA5C3);
    wait_rx(0, got);
    n_total++; if (got[15:0] !== want) $display("FAIL mode0_rx: got %h want %h", got[15:0], want); else n_pass++;
    n_total++; if (sl_in[0][15:0] !== 16'hA5C3) $display("FAIL mode0_slave_rx: got %h want a5c3", sl_in[0][15:0]); else n_pass++;
    n_total++; if (sl_cs_cyc[0] != 68) $display("FAIL mode0_cs_cycles: got %0d want 68", sl_cs_cyc[0]); else n_pass++;
    n_total++; if (sl_rise[0] != 16) $display("FAIL mode0_sclk_rises: got %0d want 16", sl_rise[0]); else n_pass++;
    n_total++; if ({cs[0], mosi[0]} !== 2'b10) $display("FAIL mode0_idle_bus: cs,mosi got %b want 10", {cs[0], mosi[0]}); else n_pass++;
  endtask

  task automatic test_mode3();
    logic [31:0] got;
    logic [15:0] want;
    want = LB ? 16'h8001 : 16'h7FFE;
    n_total++; if (sclk[1] !== 1'b1) $display("FAIL mode3_idle_sclk_before: got %b want 1", sclk[1]); else n_pass++;
    sl_tx[1] = 32'h7FFE;
    send_cmd(1, 32'h8001);
    wait_rx(1, got);
    n_total++; if (got[15:0] !== want) $display("FAIL mode3_rx: got %h want %h", got[15:0], want); else n_pass++;
    n_total++; if (sl_in[1][15:0] !== 16'h8001) $display("FAIL mode3_slave_rx: got %h want 8001", sl_in[1][15:0]); else n_pass++;
    n_total++; if (sclk[1] !== 1'b1) $display("FAIL mode3_idle_sclk_after: got %b want 1", sclk[1]); else n_pass++;
    n_total++; if (sl_rise[1] != 16) $display("FAIL mode3_sclk_rises: got %0d want 16", sl_rise[1]); else n_pass++;
  endtask

  task automatic test_len8_inv_cs();
    logic [31:0] got;
    logic [7:0] want;
    want = LB ? 8'h5A : 8'hC3;
    n_total++; if (cs[2] !== 1'b0) $display("FAIL len8_cs_idle: got %b want 0", cs[2]); else n_pass++;
    sl_tx[2] = 32'hC3;
    send_cmd(2, 32'h5A);
    wait_rx(2, got);
    n_total++; if (got[7:0] !== want) $display("FAIL len8_rx: got %h want %h", got[7:0], want); else n_pass++;
    n_total++; if (sl_in[2][7:0] !== 8'h5A) $display("FAIL len8_slave_rx: got %h want 5a", sl_in[2][7:0]); else n_pass++;
    n_total++; if (sl_cs_cyc[2] != 18) $display("FAIL len8_cs_cycles: got %0d want 18", sl_cs_cyc[2]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int n, ready_seen;
    sl_tx[0] = 32'h1357;
    send_cmd(0, 32'h0F0F);
    n = 0;
    while (rx_valid[0] !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    sl_tx[0] = 32'h2468;
    d0_tx = 16'hF0F0;
    cmd_valid[0] = 1'b1;
    ready_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready[0] === 1'b1) ready_seen++;
    end
    cmd_valid[0] = 1'b0;
    n_total++; if (ready_seen != 0 || rx_valid[0] !== 1'b1) $display("FAIL b2b_ready_blocked: ready cycles %0d rx_valid %b, want 0 and 1", ready_seen, rx_valid[0]); else n_pass++;
    n_total++; if (busy[0] !== 1'b0) $display("FAIL b2b_busy_idle: got %b want 0", busy[0]); else n_pass++;
    wait_rx(0, got);
    n_total++; if (got[15:0] !== (LB ? 16'h0F0F : 16'h1357)) $display("FAIL b2b_first_word: got %h want %h", got[15:0], LB ? 16'h0F0F : 16'h1357); else n_pass++;
    send_cmd(0, 32'hF0F0);
    wait_rx(0, got);
    n_total++; if (got[15:0] !== (LB ? 16'hF0F0 : 16'h2468)) $display("FAIL b2b_second_word: got %h want %h", got[15:0], LB ? 16'hF0F0 : 16'h2468); else n_pass++;
    n_total++; if (sl_in[0][15:0] !== 16'hF0F0) $display("FAIL b2b_slave_second: got %h want f0f0", sl_in[0][15:0]); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] got;
    int n, pulses;
    sl_tx[0] = 32'hFFFF;
    send_cmd(0, 32'h3C3C);
    n = 0;
    while (sl_rise[0] < 8 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      n_total++;
      $display("FAIL midreset_reach_bit7: sclk rises %0d, required 8 within %0d cycles", sl_rise[0], BOUND);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_total++; if (cs[0] !== 1'b1) $display("FAIL midreset_cs: got %b want 1", cs[0]); else n_pass++;
    n_total++; if (sclk[0] !== 1'b0) $display("FAIL midreset_sclk: got %b want 0", sclk[0]); else n_pass++;
    n_total++; if ({rx_valid[0], busy[0], mosi[0]} !== 3'b000) $display("FAIL midreset_flags: rx_valid,busy,mosi got %b want 000", {rx_valid[0], busy[0], mosi[0]}); else n_pass++;
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rx_valid[0] === 1'b1) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL midreset_no_rx_pulse: got %0d rx_valid cycles want 0", pulses); else n_pass++;
    sl_tx[0] = 32'h0001;
    send_cmd(0, 32'hBEEF);
    wait_rx(0, got);
    n_total++; if (got[15:0] !== (LB ? 16'hBEEF : 16'h0001)) $display("FAIL midreset_recovery_rx: got %h want %h", got[15:0], LB ? 16'hBEEF : 16'h0001); else n_pass++;
    n_total++; if (sl_in[0][15:0] !== 16'hBEEF) $display("FAIL midreset_recovery_slave: got %h want beef", sl_in[0][15:0]); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [31:0] got;
    logic [15:0] want;
    want = LB ? 16'h1234 : 16'hFFFF;
    sl_tx[0] = 32'hFFFF;
    send_cmd(0, 32'h1234);
    wait_rx(0, got);
    n_total++; if (got[15:0] !== want) $display("FAIL loopback_rx: got %h want %h", got[15:0], want); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_len8_inv_cs();
    test_back_to_back();
    test_reset_mid_shift();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adi_spi_master_engine.md
# adi_spi_master_engine

Synthesizable SPI initiator that drives SCLK/CS/MOSI and captures MISO, for use as the bus-side stimulus source against SPI responder DUTs and against the SPI VIP in slave mode. Each accepted command performs one full-duplex word transfer of DATA_DLENGTH bits. The received word is returned on a single-entry response buffer. Mode (CPOL/CPHA), CS polarity and word length use the same parameter semantics as the SPI VIP interface, so a bench can pair the two directly.

## Interface
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing.
- INV_CS, 0, 0: CS active-low; 1: CS active-high.
- DATA_DLENGTH, 16, bits per transfer, MSB first; legal range 2..32.
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.
- CS_TO_SCLK, 2, clk cycles from CS assertion to first SCLK edge; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- s_cmd_valid  in  1  command request.
- s_cmd_ready  out  1  engine can accept a command.
- s_cmd_data  in  DATA_DLENGTH  word to shift out on MOSI.
- m_rx_valid  out  1  received word available.
- m_rx_ready  in  1  consumer accepts the received word.
- m_rx_data  out  DATA_DLENGTH  word captured from MISO.
- busy  out  1  high from command acceptance until the end of GAP.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_cs  out  1  chip select.

## Operation
- Reset values: s_cmd_ready=0 during reset, 1 on first cycle after reset; m_rx_valid=0; m_rx_data=0; busy=0; spi_sclk=CPOL; spi_mosi=0; spi_cs=~INV_CS (deasserted).
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: s_cmd_ready = ~m_rx_valid. On s_cmd_valid & s_cmd_ready: latch s_cmd_data, -> SETUP.
- SETUP: CS asserted, MOSI = tx MSB; lasts CS_TO_SCLK cycles; -> SHIFT.
- SHIFT: 2*DATA_DLENGTH SCLK edges, one every CLK_DIV cycles. Sample edge: capture spi_miso into rx shift register. Shift edge: present next tx bit on MOSI. CPHA=1: first leading edge drives the MSB (MOSI already holds it, no shift); final trailing edge samples LSB. CPHA=0: final trailing edge does not shift. SCLK ends at CPOL. -> HOLD.
- HOLD: CLK_DIV cycles, CS still asserted; on exit CS deasserts, MOSI=0, rx word loads into m_rx_data, m_rx_valid=1. -> GAP.
- GAP: CLK_DIV cycles CS deasserted (minimum CS-high time); -> IDLE.
- m_rx_valid clears on m_rx_valid & m_rx_ready. Commands are not accepted while m_rx_valid=1 (single-entry buffer; no overwrite, no drop).
- Counters: half-period counter 8 bits, edge counter clog2(2*DATA_DLENGTH)+1 bits; both reload on state entry.

## Timing
- Command accepted at cycle T; CS asserts at T+1.
- CS asserted for CS_TO_SCLK + 2*DATA_DLENGTH*CLK_DIV + CLK_DIV cycles.
- m_rx_valid rises in the same cycle CS deasserts.
- Earliest next acceptance: CLK_DIV+1 cycles after CS deassert, if m_rx_ready held 1.
- MISO sampled combinationally from the pin in the clk cycle that toggles SCLK to the sample edge (no extra sync stage).
- resetn=0 mid-transfer: next clk edge forces all reset values; partial rx data discarded, no m_rx_valid pulse.
- s_cmd_valid deasserted without handshake: no effect; s_cmd_data only sampled on handshake.

## Configuration
- ADI_SPI_MASTER_LOOPBACK_EN defined: spi_miso input is ignored; the rx shift register samples the internal MOSI value, so m_rx_data equals the transmitted word. Not defined: normal spi_miso sampling. Port list identical in both builds.

## Structure
- Package adi_spi_master_pkg: state enum typedef (IDLE, SETUP, SHIFT, HOLD, GAP), counter width localparams.
- Sub-module adi_spi_master_sclk_gen: half-period counter, SCLK toggle, leading/trailing edge strobes, edge count done flag.

## Test plan
- Mode 0, DIV=2, CS_TO_SCLK=2, tx 0xA5C3, slave VIP returns 0xCAFE -> VIP sees 0xA5C3, m_rx_data=0xCAFE, CS low exactly 68 cycles, 16 SCLK rising edges.
- Mode 3 (CPOL=1,CPHA=1), tx 0x8001, miso 0x7FFE -> SCLK idles high, m_rx_data=0x7FFE, VIP receives 0x8001.
- Two back-to-back commands, m_rx_ready=0 -> second s_cmd_ready stays 0 until first word consumed; no data lost, order preserved.
- resetn pulsed low mid-SHIFT at bit 7 -> next cycle CS deasserted, SCLK=CPOL, m_rx_valid=0; new command after reset completes correctly.
- ADI_SPI_MASTER_LOOPBACK_EN defined, spi_miso tied 1, tx 0x1234 -> m_rx_data=0x1234.
- DATA_DLENGTH=8, DIV=1, INV_CS=1, tx 0x5A -> CS high for 1+16+1=18 cycles, VIP (INV_CS=1) receives 0x5A.
